// File: rtl/alu_op_issue.sv
// ALU_ctl decode, registered issue stage and in-order branch tag FIFO.
// Optional illegal-op output enabled by ALU_ILLEGAL_TRAP_EN.
module alu_op_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               ALU_ctl,
  input  logic                     res_valid,
  input  logic                     res_zero,
  output logic                     br_valid,
  output logic                     br_taken,
  output logic [$clog2(DEPTH):0]   pending,
  input  logic                     flush
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic                     illegal
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_LT  = 4'b0111;
  localparam logic [3:0] CTL_GE  = 4'b1000;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_SLL = 4'b1001;
  localparam logic [3:0] CTL_SRL = 4'b1010;

  typedef struct packed {
    logic is_br;
    logic pol;
  } tag_t;

  logic [3:0] dec_ctl;
  tag_t       dec_tag;
  logic       dec_ill;
  tag_t       out_tag;
  tag_t       tags [DEPTH];
  tag_t       head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic       issue;
  logic       accept;
  logic       push;
  logic       pop;
  logic       f7_zero;
  logic       f7_alt;

  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Combinational decode of the incoming request into ctl code and tag.
  always_comb begin
    dec_ctl = CTL_AND;
    dec_tag = '0;
    dec_ill = 1'b0;
    unique case (1'b1)
      (alu_op == 2'b00): dec_ctl = CTL_ADD;
      (alu_op == 2'b01): begin
        case (funct3)
          3'b000: begin
            dec_ctl = CTL_SUB;
            dec_tag = '{is_br: 1'b1, pol: 1'b1};
          end
          3'b001: begin
            dec_ctl = CTL_SUB;
            dec_tag = '{is_br: 1'b1, pol: 1'b0};
          end
          3'b100: begin
            dec_ctl = CTL_LT;
            dec_tag = '{is_br: 1'b1, pol: 1'b0};
          end
          3'b101: begin
            dec_ctl = CTL_GE;
            dec_tag = '{is_br: 1'b1, pol: 1'b0};
          end
          default: dec_ill = 1'b1;
        endcase
      end
      (alu_op == 2'b10): begin
        unique case (1'b1)
          (funct3 == 3'b000 && f7_zero): dec_ctl = CTL_ADD;
          (funct3 == 3'b000 && f7_alt):  dec_ctl = CTL_SUB;
          (funct3 == 3'b001 && f7_zero): dec_ctl = CTL_SLL;
          (funct3 == 3'b101 && f7_zero): dec_ctl = CTL_SRL;
          (funct3 == 3'b111 && f7_zero): dec_ctl = CTL_AND;
          (funct3 == 3'b110 && f7_zero): dec_ctl = CTL_OR;
          (funct3 == 3'b100 && f7_alt):  dec_ctl = CTL_NOR;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        unique case (1'b1)
          (funct3 == 3'b000):            dec_ctl = CTL_ADD;
          (funct3 == 3'b111):            dec_ctl = CTL_AND;
          (funct3 == 3'b110):            dec_ctl = CTL_OR;
          (funct3 == 3'b001 && f7_zero): dec_ctl = CTL_SLL;
          (funct3 == 3'b101 && f7_zero): dec_ctl = CTL_SRL;
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign issue = out_valid & out_ready &
                 ((pending < PW'(DEPTH)) | res_valid);
  assign in_ready = ~flush & (~out_valid | issue);
  assign accept   = in_valid & in_ready;
  assign push     = issue & ~flush;
  assign pop      = res_valid & (pending != '0) & ~flush;
  assign head     = tags[rptr];

  // Issue register holding the decoded op until the EX stage takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALU_ctl   <= CTL_AND;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ALU_ctl   <= dec_ctl;
      out_tag   <= dec_tag;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  // Illegal flag travels with the op in the issue register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (flush) begin
      illegal <= 1'b0;
    end else if (accept) begin
      illegal <= dec_ill;
    end else if (issue) begin
      illegal <= 1'b0;
    end
  end
`else
  logic unused_ill;
  assign unused_ill = dec_ill;
`endif

  // Tag storage, written at the tail on every issued op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
    end else if (push) begin
      tags[wptr] <= out_tag;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      pending <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      pending <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Branch resolution from the head tag and the returning zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else if (pop) begin
      br_valid <= head.is_br;
      br_taken <= head.is_br &
                  (head.pol ? res_zero : ~res_zero);
    end else begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue.
// Checks illegal output when ALU_ILLEGAL_TRAP_EN is defined.
module tb_alu_op_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALU_ctl;
  logic       res_valid;
  logic       res_zero;
  logic       br_valid;
  logic       br_taken;
  logic [2:0] pending;
  logic       flush;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_issue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_ctl   (ALU_ctl),
    .res_valid (res_valid),
    .res_zero  (res_zero),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .pending   (pending),
    .flush     (flush)
`ifdef ALU_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op,
                     input logic [2:0] f3,
                     input logic [6:0] f7);
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    alu_op = 2'b00;
    funct3 = 3'b000;
    funct7 = 7'b0;
    out_ready = 1'b0;
    res_valid = 1'b0;
    res_zero = 1'b0;
    flush = 1'b0;
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_ctl", ALU_ctl, 0);
    chk("rst_pend", pending, 0);
    chk("rst_brv", br_valid, 0);
    #4 rst_n = 1'b1;
    tick();
    chk("rst_inr", in_ready, 1);

    // R-type sub
    req(2'b10, 3'b000, 7'b0100000);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sub_ov", out_valid, 1);
    chk("sub_ctl", ALU_ctl, 4'b0110);
    tick();
    chk("sub_pend", pending, 1);
    chk("sub_ov0", out_valid, 0);

    // backpressure on slli
    out_ready = 1'b0;
    req(2'b11, 3'b001, 7'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ov", out_valid, 1);
      chk("bp_ctl", ALU_ctl, 4'b1001);
      chk("bp_inr", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_inr1", in_ready, 1);
    tick();
    out_ready = 1'b0;
    chk("bp_ov0", out_valid, 0);
    chk("bp_pend", pending, 2);

    // drain two non-branch tags
    res_valid = 1'b1;
    tick();
    chk("nb_brv", br_valid, 0);
    chk("nb_pend", pending, 1);
    tick();
    chk("nb_pend0", pending, 0);
    // result with empty FIFO ignored
    tick();
    res_valid = 1'b0;
    chk("emp_brv", br_valid, 0);
    chk("emp_pend", pending, 0);

    // bne, beq, blt back to back
    out_ready = 1'b1;
    req(2'b01, 3'b001, 7'h55);
    tick();
    chk("br1_ctl", ALU_ctl, 4'b0110);
    req(2'b01, 3'b000, 7'h2a);
    tick();
    chk("br2_ctl", ALU_ctl, 4'b0110);
    req(2'b01, 3'b100, 7'h00);
    tick();
    in_valid = 1'b0;
    chk("br3_ctl", ALU_ctl, 4'b0111);
    tick();
    out_ready = 1'b0;
    chk("br_pend", pending, 3);
    res_valid = 1'b1;
    res_zero = 1'b0;
    tick();
    chk("bne_v", br_valid, 1);
    chk("bne_t", br_taken, 1);
    res_zero = 1'b0;
    tick();
    chk("beq_v", br_valid, 1);
    chk("beq_t", br_taken, 0);
    res_zero = 1'b1;
    tick();
    chk("blt_v", br_valid, 1);
    chk("blt_t", br_taken, 0);
    res_valid = 1'b0;
    res_zero = 1'b0;
    tick();
    chk("br_pulse", br_valid, 0);
    chk("br_pend0", pending, 0);

    // fill FIFO, fifth op stalls
    out_ready = 1'b1;
    req(2'b00, 3'b010, 7'h7f);
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    chk("full_pend", pending, 4);
    chk("full_ov", out_valid, 1);
    chk("full_inr", in_ready, 0);
    tick();
    chk("full_hold", out_valid, 1);
    chk("full_pend2", pending, 4);
    res_valid = 1'b1;
    #1 chk("full_inr1", in_ready, 1);
    tick();
    res_valid = 1'b0;
    out_ready = 1'b0;
    chk("full_ov0", out_valid, 0);
    chk("full_pend3", pending, 4);
    chk("full_brv", br_valid, 0);

    // flush with op held, pending=2 and result
    res_valid = 1'b1;
    tick();
    tick();
    res_valid = 1'b0;
    chk("fl_pre", pending, 2);
    req(2'b10, 3'b000, 7'b0);
    tick();
    in_valid = 1'b0;
    chk("fl_ov1", out_valid, 1);
    flush = 1'b1;
    res_valid = 1'b1;
    #1 chk("fl_inr", in_ready, 0);
    tick();
    flush = 1'b0;
    res_valid = 1'b0;
    chk("fl_ov", out_valid, 0);
    chk("fl_pend", pending, 0);
    chk("fl_brv", br_valid, 0);

    // illegal R-type op
    req(2'b10, 3'b100, 7'b0);
    tick();
    in_valid = 1'b0;
    chk("ill_ov", out_valid, 1);
    chk("ill_ctl", ALU_ctl, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("ill_flag", illegal, 1);
`endif
    // illegal branch funct3 is non-branch
    out_ready = 1'b1;
    req(2'b01, 3'b010, 7'b0);
    tick();
    in_valid = 1'b0;
    chk("illb_ctl", ALU_ctl, 0);
    chk("illb_pend", pending, 1);
    tick();
    out_ready = 1'b0;
    chk("illb_pend2", pending, 2);
    res_valid = 1'b1;
    res_zero = 1'b1;
    tick();
    chk("illb_brv1", br_valid, 0);
    tick();
    res_valid = 1'b0;
    res_zero = 1'b0;
    chk("illb_brv2", br_valid, 0);
    chk("illb_pend0", pending, 0);

    // async reset mid-stream with pending=3
    out_ready = 1'b1;
    req(2'b11, 3'b000, 7'b0);
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mr_pend", pending, 3);
    chk("mr_ov", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov0", out_valid, 0);
    chk("mr_ctl", ALU_ctl, 0);
    chk("mr_pend0", pending, 0);
    chk("mr_brv", br_valid, 0);
    #1 rst_n = 1'b1;
    #1 chk("mr_inr", in_ready, 1);
    tick();
    chk("mr_pend1", pending, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Decode stage that sits in front of the ALU. It is the producing end of the ALU_ctl encoding and the consuming end of the ALU zero flag.
- Decodes alu_op/funct3/funct7 into the 4-bit ALU_ctl code. The code is held in a registered valid/ready issue stage.
- Keeps an in-order tag FIFO of issued ops. When each ALU result returns, the block turns the zero flag into a registered branch-taken decision.
- Sits at the ID/EX boundary. Branch resolution feeds MEM-stage PC redirect.

Parameters:
- DEPTH, 4: number of outstanding issued-but-unresolved ops in the tag FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode request valid.
- in_ready  out  1  block can accept a request.
- alu_op  in  2  00 ld/st, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7 (ignored for alu_op 00/01).
- out_valid  out  1  ALU_ctl holds a valid op.
- out_ready  in  1  ALU/EX stage accepts the op.
- ALU_ctl  out  4  ALU operation code.
- res_valid  in  1  one ALU result returns this cycle, in issue order.
- res_zero  in  1  ALU zero flag for that result.
- br_valid  out  1  registered: resolved op was a branch.
- br_taken  out  1  registered branch decision, meaningful when br_valid=1.
- pending  out  clog2(DEPTH)+1  tag FIFO occupancy.
- flush  in  1  synchronous pipeline flush.

Behaviour:
- Encoding: and=0000, or=0001, add=0010, sub=0110, lt=0111, ge=1000, nor=1100, sll=1001, srl=1010.
- Decode for alu_op=00: add.
- Decode for alu_op=01:
  - funct3 000 (beq) and 001 (bne) → sub.
  - funct3 100 (blt) → 0111.
  - funct3 101 (bge) → 1000.
  - Other funct3 values are illegal.
- Decode for alu_op=10:
  - 000/0000000 add; 000/0100000 sub.
  - 001/0000000 sll; 101/0000000 srl.
  - 111/0000000 and; 110/0000000 or.
  - 100/0100000 nor.
  - Anything else is illegal.
- Decode for alu_op=11:
  - funct3 000 add, 111 and, 110 or.
  - funct3 001 sll and 101 srl, both only when funct7=0000000.
  - Anything else is illegal.
- Illegal ops decode to ALU_ctl=0000 and are treated as non-branch.
- Tag per op is {is_br, pol}:
  - pol=1 (taken when zero) for beq.
  - pol=0 (taken when not zero) for bne, blt, bge.
  - is_br=0 for every non-branch op.
- Issue register:
  - issue = out_valid & out_ready & (pending<DEPTH | res_valid).
  - in_ready = ~flush & (~out_valid | issue), combinational.
  - A request is accepted on in_valid & in_ready. out_valid and ALU_ctl update on the next edge, so latency is 1 cycle.
  - ALU_ctl stays stable while out_valid=1 and no issue occurs.
  - Back-to-back accept+issue sustains 1 op/cycle.
- Tag FIFO:
  - Push on issue; pop on res_valid while pending>0.
  - Simultaneous push and pop leaves pending unchanged; this is allowed at full.
  - res_valid with pending=0 is ignored: no pop, br_valid stays 0.
  - Read/write pointers wrap modulo DEPTH.
- Resolution: on the edge after a pop:
  - br_valid = head.is_br.
  - br_taken = head.is_br & (head.pol ? res_zero : ~res_zero).
  - br_valid is a 1-cycle pulse per resolved branch.
- Flush: has priority over all other events. On the next edge it clears out_valid, pending, br_valid and br_taken, and resets the pointers. A result arriving in the flush cycle is discarded.
- Reset (async, rst_n=0):
  - out_valid=0, ALU_ctl=0000, br_valid=0, br_taken=0, pending=0, pointers=0.
  - After release, in_ready=1.
- Reset asserted mid-operation discards every held op and tag immediately.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal (1 bit), registered alongside ALU_ctl and valid only while out_valid=1. Reset value is 0; flush clears it.
  - Illegal ops are still issued as 0000/non-branch.
- Undefined: the port is absent. Illegal ops silently decode to 0000 with no indication.

Test Plan:
- Reset: rst_n=0 mid-stream with pending=3 → out_valid=0, ALU_ctl=0000, pending=0, br_valid=0 immediately; in_ready=1 after release.
- R-type sub: alu_op=10, funct3=000, funct7=0100000, out_ready=1 → next cycle out_valid=1, ALU_ctl=0110; issues, pending=1.
- Backpressure: I-type slli (11/001/0000000) with out_ready=0 for 3 cycles → ALU_ctl=1001 held stable, in_ready=0; with out_ready=1 it issues once.
- Branches issued in order bne, beq, blt; results res_zero=0, 0, 1 → br_valid pulses with br_taken=1, 0, 0.
- Full FIFO: 4 issues with no results → pending=4 and the 5th op stalls; res_valid in the same cycle as out_ready lets the 5th op issue with pending staying 4.
- Flush with out_valid=1, pending=2, and res_valid in the same cycle → next cycle out_valid=0, pending=0, br_valid=0. With ALU_ILLEGAL_TRAP_EN, a following op 10/100/0000000 shows illegal=1 and ALU_ctl=0000.
